// File: rtl/ntt_ct_butterfly_tail.sv
`default_nettype none
// ============================================================================
// Module  : ntt_ct_butterfly_tail
// Purpose : Cooley-Tukey butterfly tail for the q=12289 NTT: aligns U with the
//           reduced product, forms (U+V, U-V) mod Q, counts beats and stages.
//           Optional macro NTT_TAIL_DIV2_EN scales both outputs by 2^-1 mod Q.
// Revision: 1.0 - initial release
// ============================================================================
module ntt_ct_butterfly_tail #(
    parameter int DATA_WIDTH = 14,
    parameter int Q          = 12289,
    parameter int MUL_LAT    = 4,
    parameter int NUM_BF     = 256,
    parameter int STAGES     = 9,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_in,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] u_in,
    input  logic [DATA_WIDTH-1:0] red_in,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] x_out,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic                  last_out,
    output logic [3:0]            stage_out,
    output logic                  done_out
);

    localparam logic [DATA_WIDTH:0] C_Q          = (DATA_WIDTH+1)'(Q);
    localparam logic [CNT_W-1:0]    C_BF_LAST    = CNT_W'(NUM_BF - 1);
    localparam logic [3:0]          C_STAGE_LAST = 4'(STAGES - 1);

    logic [DATA_WIDTH-1:0] r_u_dly [MUL_LAT];
    logic [MUL_LAT-1:0]    r_vld_dly;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_y;
    logic [CNT_W-1:0]      r_bf_cnt;
    logic [3:0]            r_stage_cnt;
    logic                  r_done;

    logic [DATA_WIDTH-1:0] w_u;
    logic                  w_beat;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH-1:0] w_x_mod;
    logic [DATA_WIDTH-1:0] w_y_mod;
    logic [DATA_WIDTH-1:0] w_x;
    logic [DATA_WIDTH-1:0] w_y;
    logic                  w_last;

    // Delay line: delayed U/valid line up with red_in of the same operand
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                r_u_dly[i] <= '0;
            end
            r_vld_dly <= '0;
        end else begin
            r_u_dly[0] <= u_in;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_u_dly[i] <= r_u_dly[i-1];
            end
            if (clr_in) begin
                r_vld_dly <= '0;
            end else begin
                r_vld_dly[0] <= in_valid;
                for (int i = 1; i < MUL_LAT; i++) begin
                    r_vld_dly[i] <= r_vld_dly[i-1];
                end
            end
        end
    end

    assign w_u    = r_u_dly[MUL_LAT-1];
    assign w_beat = r_vld_dly[MUL_LAT-1] & ~clr_in;

    assign w_sum   = {1'b0, w_u} + {1'b0, red_in};
    assign w_diff  = {1'b0, w_u} - {1'b0, red_in};
    assign w_x_mod = (w_sum >= C_Q) ? DATA_WIDTH'(w_sum - C_Q) : w_sum[DATA_WIDTH-1:0];
    assign w_y_mod = w_diff[DATA_WIDTH] ? DATA_WIDTH'(w_diff + C_Q) : w_diff[DATA_WIDTH-1:0];

`ifdef NTT_TAIL_DIV2_EN
    // Halving mod Q: odd values borrow one Q so the sum is even before the shift
    logic [DATA_WIDTH:0] w_x_half;
    logic [DATA_WIDTH:0] w_y_half;
    assign w_x_half = {1'b0, w_x_mod} + (w_x_mod[0] ? C_Q : '0);
    assign w_y_half = {1'b0, w_y_mod} + (w_y_mod[0] ? C_Q : '0);
    assign w_x      = DATA_WIDTH'(w_x_half >> 1);
    assign w_y      = DATA_WIDTH'(w_y_half >> 1);
`else
    assign w_x = w_x_mod;
    assign w_y = w_y_mod;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
        end else begin
            r_out_valid <= w_beat;
            if (w_beat) begin
                r_x <= w_x;
                r_y <= w_y;
            end
        end
    end

    // Counters describe the beat currently on the outputs and advance after it
    assign w_last = r_out_valid && (r_bf_cnt == C_BF_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bf_cnt    <= '0;
            r_stage_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_last && (r_stage_cnt == C_STAGE_LAST);
            if (clr_in) begin
                r_bf_cnt    <= '0;
                r_stage_cnt <= '0;
            end else if (r_out_valid) begin
                if (w_last) begin
                    r_bf_cnt    <= '0;
                    r_stage_cnt <= (r_stage_cnt == C_STAGE_LAST) ? 4'd0 : r_stage_cnt + 4'd1;
                end else begin
                    r_bf_cnt <= r_bf_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign x_out     = r_x;
    assign y_out     = r_y;
    assign last_out  = w_last;
    assign stage_out = r_stage_cnt;
    assign done_out  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ntt_ct_butterfly_tail.sv
`default_nettype none
// ============================================================================
// Module  : tb_ntt_ct_butterfly_tail
// Purpose : Self-checking bench: directed arithmetic vectors plus stage,
//           transform, flush and reset sequences against a small beat model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ntt_ct_butterfly_tail;

    localparam int MUL_LAT = 4;
    localparam int LAT     = MUL_LAT + 1;
    localparam int NUM_BF  = 256;
    localparam int STAGES  = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr_in = 1'b0;
    logic        in_valid = 1'b0;
    logic [13:0] u_in = '0;
    logic [13:0] red_in;
    logic [13:0] v_drv = '0;
    logic        out_valid;
    logic [13:0] x_out;
    logic [13:0] y_out;
    logic        last_out;
    logic [3:0]  stage_out;
    logic        done_out;

    logic [13:0] v_pipe [MUL_LAT];

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;

    // Beat model state
    logic [LAT-1:0] ev = '0;
    int m_bf    = 0;
    int m_stage = 0;
    logic m_done = 1'b0;

    typedef struct {
        logic [13:0] u;
        logic [13:0] v;
        logic [13:0] ex;
        logic [13:0] ey;
    } vec_t;

    vec_t vecs [7];

    ntt_ct_butterfly_tail #(
        .DATA_WIDTH (14),
        .Q          (12289),
        .MUL_LAT    (MUL_LAT),
        .NUM_BF     (NUM_BF),
        .STAGES     (STAGES),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr_in    (clr_in),
        .in_valid  (in_valid),
        .u_in      (u_in),
        .red_in    (red_in),
        .out_valid (out_valid),
        .x_out     (x_out),
        .y_out     (y_out),
        .last_out  (last_out),
        .stage_out (stage_out),
        .done_out  (done_out)
    );

    always #5 clk = ~clk;

    // Stand-in for the reduction stage: V appears MUL_LAT cycles after issue
    always @(posedge clk) begin
        v_pipe[0] <= v_drv;
        for (int i = 1; i < MUL_LAT; i++) begin
            v_pipe[i] <= v_pipe[i-1];
        end
    end
    assign red_in = v_pipe[MUL_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        ev      = '0;
        m_bf    = 0;
        m_stage = 0;
        m_done  = 1'b0;
    endtask

    // One clock cycle: drive, advance the model, compare the control outputs
    task automatic step(input logic iv, input logic [13:0] u, input logic [13:0] v, input logic clr);
        logic cur_ov;
        logic cur_last;
        logic nxt_done;
        in_valid = iv;
        u_in     = u;
        v_drv    = v;
        clr_in   = clr;
        cur_ov   = ev[LAT-1];
        cur_last = cur_ov && (m_bf == NUM_BF - 1);
        nxt_done = cur_last && (m_stage == STAGES - 1);
        @(posedge clk);
        #1;
        if (clr) begin
            ev      = '0;
            m_bf    = 0;
            m_stage = 0;
        end else begin
            ev = {ev[LAT-2:0], iv};
            if (cur_ov) begin
                if (cur_last) begin
                    m_bf    = 0;
                    m_stage = (m_stage == STAGES - 1) ? 0 : m_stage + 1;
                end else begin
                    m_bf++;
                end
            end
        end
        m_done = nxt_done;
        chk("out_valid", 32'(out_valid), 32'(ev[LAT-1]));
        chk("last_out", 32'(last_out), 32'(ev[LAT-1] && (m_bf == NUM_BF - 1)));
        chk("stage_out", 32'(stage_out), 32'(m_stage));
        chk("done_out", 32'(done_out), 32'(m_done));
        if (done_out) n_done++;
        in_valid = 1'b0;
        clr_in   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_x_out"}, 32'(x_out), 0);
        chk({tag, "_y_out"}, 32'(y_out), 0);
        chk({tag, "_last_out"}, 32'(last_out), 0);
        chk({tag, "_stage_out"}, 32'(stage_out), 0);
        chk({tag, "_done_out"}, 32'(done_out), 0);
    endtask

    initial begin
        int issued;
`ifdef NTT_TAIL_DIV2_EN
        vecs[0] = '{u: 14'd12000, v: 14'd1000,  ex: 14'd6500,  ey: 14'd5500};
        vecs[1] = '{u: 14'd5,     v: 14'd10,    ex: 14'd6152,  ey: 14'd6142};
        vecs[2] = '{u: 14'd0,     v: 14'd0,     ex: 14'd0,     ey: 14'd0};
        vecs[3] = '{u: 14'd12288, v: 14'd12288, ex: 14'd12288, ey: 14'd0};
        vecs[4] = '{u: 14'd6144,  v: 14'd6145,  ex: 14'd0,     ey: 14'd6144};
        vecs[5] = '{u: 14'd0,     v: 14'd1,     ex: 14'd6145,  ey: 14'd6144};
        vecs[6] = '{u: 14'd3000,  v: 14'd4000,  ex: 14'd3500,  ey: 14'd11789};
`else
        vecs[0] = '{u: 14'd12000, v: 14'd1000,  ex: 14'd711,   ey: 14'd11000};
        vecs[1] = '{u: 14'd5,     v: 14'd10,    ex: 14'd15,    ey: 14'd12284};
        vecs[2] = '{u: 14'd0,     v: 14'd0,     ex: 14'd0,     ey: 14'd0};
        vecs[3] = '{u: 14'd12288, v: 14'd12288, ex: 14'd12287, ey: 14'd0};
        vecs[4] = '{u: 14'd6144,  v: 14'd6145,  ex: 14'd0,     ey: 14'd12288};
        vecs[5] = '{u: 14'd0,     v: 14'd1,     ex: 14'd1,     ey: 14'd12288};
        vecs[6] = '{u: 14'd3000,  v: 14'd4000,  ex: 14'd7000,  ey: 14'd11289};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        model_reset();

        // Arithmetic vectors, one at a time, with exact latency and hold checks
        foreach (vecs[k]) begin
            step(1'b1, vecs[k].u, vecs[k].v, 1'b0);
            repeat (MUL_LAT) step(1'b0, 14'd0, 14'd0, 1'b0);
            chk("vec_x_out", 32'(x_out), 32'(vecs[k].ex));
            chk("vec_y_out", 32'(y_out), 32'(vecs[k].ey));
            step(1'b0, 14'd0, 14'd0, 1'b0);
            chk("hold_x_out", 32'(x_out), 32'(vecs[k].ex));
            chk("hold_y_out", 32'(y_out), 32'(vecs[k].ey));
        end

        // Stage boundary from a clean count
        step(1'b0, 14'd0, 14'd0, 1'b1);
        for (int i = 0; i < NUM_BF + 1; i++) begin
            step(1'b1, 14'(i % 12289), 14'd7, 1'b0);
        end
        repeat (LAT + 1) step(1'b0, 14'd0, 14'd0, 1'b0);
        chk("stage_after_boundary", 32'(stage_out), 1);

        // Flush with three operands in flight; the clr-cycle operand is dropped too
        repeat (3) step(1'b1, 14'd100, 14'd50, 1'b0);
        step(1'b1, 14'd100, 14'd50, 1'b1);
        repeat (LAT + 3) step(1'b0, 14'd0, 14'd0, 1'b0);
        chk("flush_stage", 32'(stage_out), 0);

        // Full transform with random idle gaps
        n_done = 0;
        issued = 0;
        while (issued < NUM_BF * STAGES) begin
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, 14'd0, 14'd0, 1'b0);
            end else begin
                step(1'b1, 14'($urandom_range(0, 12288)), 14'($urandom_range(0, 12288)), 1'b0);
                issued++;
            end
        end
        repeat (LAT + 3) step(1'b0, 14'd0, 14'd0, 1'b0);
        chk("done_pulses", 32'(n_done), 1);
        chk("stage_after_done", 32'(stage_out), 0);

        // Asynchronous reset mid stage 4 with operands in flight
        for (int i = 0; i < 4 * NUM_BF + 20; i++) begin
            step(1'b1, 14'd9, 14'd3, 1'b0);
        end
        chk("pre_reset_stage", 32'(stage_out), 4);
        #3;
        rst = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        n_done = 0;
        repeat (LAT + 3) step(1'b0, 14'd0, 14'd0, 1'b0);
        chk("post_reset_done", 32'(n_done), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ntt_ct_butterfly_tail.md
Name: ntt_ct_butterfly_tail

Overview:
- Downstream consumer of the Plantard reduction stage in the 512-point NTT datapath (q = 12289, 14-bit coefficients).
- Receives the reduced product V = w·b mod q from the reduction stage output.
- Delays the matching U operand and a valid bit by the reduction pipeline depth, then forms the Cooley-Tukey outputs X = U+V mod q and Y = U−V mod q.
- Counts butterflies per stage and per transform and flags stage-last and transform-done to the address/control FSM.

Parameters:
DATA_WIDTH, 14, coefficient width
Q, 12289, modulus
MUL_LAT, 4, cycles from operand issue into the reduction stage until its C_out is valid
NUM_BF, 256, butterflies per NTT stage
STAGES, 9, stages per transform
CNT_W, 8, width of butterfly counter (must satisfy 2^CNT_W >= NUM_BF)

Ports:
clk  in  1  clock, all state rising-edge
rst  in  1  asynchronous active-low reset
clr_in  in  1  synchronous flush: clears valid pipeline and counters
in_valid  in  1  high in the cycle the operand is issued to the reduction stage
u_in  in  DATA_WIDTH  U operand, issued together with in_valid; must be < Q
red_in  in  DATA_WIDTH  reduction-stage C_out, in [0,Q), valid MUL_LAT cycles after issue
out_valid  out  1  X/Y valid
x_out  out  DATA_WIDTH  (U+V) mod Q
y_out  out  DATA_WIDTH  (U−V) mod Q
last_out  out  1  high with the NUM_BF-th out_valid beat of a stage
stage_out  out  4  index of the stage the current beat belongs to, 0..STAGES-1
done_out  out  1  one-cycle pulse after the last beat of stage STAGES-1

Behaviour:
- Reset (rst=0, asynchronous): the following clear to 0 immediately: all delay-line registers, valid pipeline, x_out, y_out, out_valid, last_out, stage_out, done_out and both counters.
- Alignment delay line:
  - u_in and in_valid pass through MUL_LAT registers.
  - The delayed U and delayed valid coincide with red_in of the same operand.
  - The pipeline is free-running: no stall, no backpressure; one operand per cycle is accepted.
- Arithmetic, computed on the delayed U and red_in, then registered:
  - s = U + V, DATA_WIDTH+1 bits. X = s − Q if s >= Q, else s.
  - d = U − V, DATA_WIDTH+1 bits signed. Y = d + Q if d < 0, else d.
  - Results are specified only for U, V < Q. No range check is performed.
- Latency:
  - in_valid at cycle t gives out_valid, x_out, y_out in cycle t+MUL_LAT+1.
  - x_out and y_out hold their last value when out_valid=0.
- Counters, advanced only on the registered out_valid beat:
  - bf_cnt counts 0..NUM_BF-1.
  - last_out is asserted in the same cycle as the beat where bf_cnt == NUM_BF-1.
  - On that beat bf_cnt wraps to 0 and stage_cnt increments.
  - stage_out shows the stage of the current beat.
- Done:
  - After the last beat of stage STAGES-1, done_out pulses for exactly one cycle in the next cycle.
  - stage_cnt returns to 0 on that same edge.
  - Gaps in out_valid do not affect counting.
- clr_in:
  - Synchronous. Zeroes the delay-line valid bits, out_valid, and both counters on the next edge.
  - Operands in flight are discarded and never emerge.
  - clr_in and in_valid in the same cycle: clr wins and the operand is dropped.
  - clr_in during the done-pulse cycle: done_out still completes its pulse; counters are cleared.
- Reset mid-transform: all state is lost, no output beat or done pulse is produced for in-flight data, and counting restarts at stage 0.

Optional Feature:
Macro: NTT_TAIL_DIV2_EN
- Defined: for the inverse NTT (Gentleman-Sande scaling), X and Y are each multiplied by 2^-1 mod Q before the output register.
  - Even value z → z/2.
  - Odd value z → (z+Q)/2.
  - Latency is unchanged: the logic is combinational, placed after the modular add/sub.
- Undefined: X and Y are output unscaled.

Test Plan:
- Basic add and subtract: issue u=12000, then red_in=1000 MUL_LAT cycles later -> 5 cycles after issue: out_valid=1, x_out=711, y_out=11000.
- Negative wrap: u=5, V=10 -> x_out=15, y_out=12284. Also u=0, V=0 -> x_out=0, y_out=0.
- Stage boundary: 256 back-to-back operands -> 256 out_valid beats; last_out high only on beat 256; stage_out steps from 0 to 1 on the following beat.
- Transform completion: 9×256 beats with random idle gaps -> exactly one done_out pulse, one cycle after the final beat; stage_out=0 afterwards.
- Flush and reset: clr_in asserted while 3 operands are in flight -> none emerge and counters read 0. rst pulled low mid-stage 4 -> every output is 0 immediately.
- NTT_TAIL_DIV2_EN defined, u=12000, V=1000 -> x_out=6500, y_out=5500.
